// File: rtl/mario_pkg.sv
// Shared types and constants for the Mario sprite renderer front end.
package mario_pkg;

    typedef enum logic [1:0] {STAND, WALK, JUMP, DEAD} anim_state_t;

    localparam logic [2:0] FRAME_STAND = 3'd0;
    localparam logic [2:0] FRAME_WALK0 = 3'd1;
    localparam logic [2:0] FRAME_JUMP  = 3'd4;
    localparam logic [2:0] FRAME_DEAD  = 3'd5;

    localparam int SPRITE_W    = 16;
    localparam int SPRITE_H    = 32;
    localparam int FRAME_WORDS = 512;

    // ROM word address of a texel: frames are stacked, rows are SPRITE_W words wide.
    function automatic logic [11:0] sprite_addr(input logic [2:0] frame,
                                                input logic [4:0] row,
                                                input logic [3:0] col);
        return 12'(int'(frame) * FRAME_WORDS + int'(row) * SPRITE_W + int'(col));
    endfunction

endpackage

// File: rtl/mario_anim_fsm.sv
// Animation state machine: picks the displayed frame once per video frame tick.
module mario_anim_fsm #(
    parameter int WALK_PERIOD = 6
) (
    input  logic       pixel_clk_in,
    input  logic       rst_in,
    input  logic       frame_tick_in,
    input  logic       moving_in,
    input  logic       airborne_in,
    input  logic       dead_in,
    output logic [2:0] frame_idx_out
);
    import mario_pkg::*;

    localparam logic [5:0] WALK_LAST  = 6'(WALK_PERIOD - 1);
    localparam logic [2:0] WALK_FINAL = FRAME_WALK0 + 3'd2;

    anim_state_t state, state_nx;
    logic [5:0]  step_cnt, step_cnt_nx;
    logic [2:0]  phase, phase_nx;
    logic [2:0]  frame_nx;

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            state         <= STAND;
            step_cnt      <= '0;
            phase         <= FRAME_WALK0;
            frame_idx_out <= FRAME_STAND;
        end else begin
            state         <= state_nx;
            step_cnt      <= step_cnt_nx;
            phase         <= phase_nx;
            frame_idx_out <= frame_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        step_cnt_nx = step_cnt;
        phase_nx    = phase;
        frame_nx    = frame_idx_out;
        if (frame_tick_in) begin
            if (state == DEAD || dead_in) state_nx = DEAD;
            else if (airborne_in)         state_nx = JUMP;
            else if (moving_in)           state_nx = WALK;
            else                          state_nx = STAND;

            // Walk cycle restarts from its first frame on every entry.
            if (state_nx != WALK || state != WALK) begin
                step_cnt_nx = '0;
                phase_nx    = FRAME_WALK0;
            end else if (step_cnt == WALK_LAST) begin
                step_cnt_nx = '0;
                phase_nx    = (phase == WALK_FINAL) ? FRAME_WALK0 : phase + 3'd1;
            end else begin
                step_cnt_nx = step_cnt + 6'd1;
            end

            case (state_nx)
                WALK:    frame_nx = phase_nx;
                JUMP:    frame_nx = FRAME_JUMP;
                DEAD:    frame_nx = FRAME_DEAD;
                default: frame_nx = FRAME_STAND;
            endcase
        end
    end

endmodule

// File: rtl/mario_sprite_addr.sv
// Mario sprite box test and ROM addressing; mirroring is built when MARIO_FLIP_EN is defined.
module mario_sprite_addr #(
    parameter int SCALE_LOG2  = 1,
    parameter int WALK_PERIOD = 6,
    parameter int INIT_X      = 100,
    parameter int INIT_Y      = 400
) (
    input  logic        pixel_clk_in,
    input  logic        rst_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        frame_tick_in,
    input  logic [10:0] mario_x_in,
    input  logic [9:0]  mario_y_in,
    input  logic        moving_in,
    input  logic        facing_left_in,
    input  logic        airborne_in,
    input  logic        dead_in,
    output logic [11:0] image_addr_out,
    output logic        in_sprite_out,
    output logic [2:0]  frame_idx_out
);
    import mario_pkg::*;

    logic [10:0] x_q;
    logic [9:0]  y_q;
    logic [2:0]  frame_idx;

    mario_anim_fsm #(.WALK_PERIOD(WALK_PERIOD)) u_anim (
        .pixel_clk_in  (pixel_clk_in),
        .rst_in        (rst_in),
        .frame_tick_in (frame_tick_in),
        .moving_in     (moving_in),
        .airborne_in   (airborne_in),
        .dead_in       (dead_in),
        .frame_idx_out (frame_idx)
    );

    // Position is only sampled at the frame tick so the box never moves mid-frame.
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            x_q <= 11'(INIT_X);
            y_q <= 10'(INIT_Y);
        end else if (frame_tick_in) begin
            x_q <= mario_x_in;
            y_q <= mario_y_in;
        end
    end

    // ---- p0: box test and texel coordinates ----
    logic [11:0] dx_p0, dy_p0, colf_p0, rowf_p0;
    logic [3:0]  col_p0;
    logic [4:0]  row_p0;
    logic        hit_p0;

    always_comb begin
        dx_p0   = {1'b0, hcount_in} - {1'b0, x_q};
        dy_p0   = {2'b0, vcount_in} - {2'b0, y_q};
        colf_p0 = dx_p0 >> SCALE_LOG2;
        rowf_p0 = dy_p0 >> SCALE_LOG2;
        // Bit 11 is the borrow: the pixel lies left of / above the box.
        hit_p0  = !dx_p0[11] && (colf_p0 < 12'(SPRITE_W)) &&
                  !dy_p0[11] && (rowf_p0 < 12'(SPRITE_H));
        row_p0  = rowf_p0[4:0];
    end

`ifdef MARIO_FLIP_EN
    logic facing_q;

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in)             facing_q <= 1'b0;
        else if (frame_tick_in) facing_q <= facing_left_in;
    end

    assign col_p0 = facing_q ? 4'd15 - colf_p0[3:0] : colf_p0[3:0];
`else
    logic unused_facing;
    assign unused_facing = facing_left_in;
    assign col_p0        = colf_p0[3:0];
`endif

    // ---- p1: registered outputs ----
    logic [11:0] addr_p1;
    logic        hit_p1;

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            addr_p1 <= '0;
            hit_p1  <= 1'b0;
        end else begin
            hit_p1  <= hit_p0;
            addr_p1 <= hit_p0 ? sprite_addr(frame_idx, row_p0, col_p0) : 12'd0;
        end
    end

    assign image_addr_out = addr_p1;
    assign in_sprite_out  = hit_p1;
    assign frame_idx_out  = frame_idx;

endmodule

// File: tb/tb_mario_sprite_addr.sv
// Randomized bench for mario_sprite_addr against a frame-level behavioural model.
module tb_mario_sprite_addr;

    localparam int S  = 1;
    localparam int WP = 6;

    logic        clk = 1'b0;
    logic        rst_in = 1'b1;
    logic [10:0] hcount_in = '0;
    logic [9:0]  vcount_in = '0;
    logic        frame_tick_in = 1'b0;
    logic [10:0] mario_x_in = 11'd100;
    logic [9:0]  mario_y_in = 10'd400;
    logic        moving_in = 1'b0, facing_left_in = 1'b0;
    logic        airborne_in = 1'b0, dead_in = 1'b0;
    logic [11:0] image_addr_out;
    logic        in_sprite_out;
    logic [2:0]  frame_idx_out;

    always #5 clk = ~clk;

    mario_sprite_addr #(.SCALE_LOG2(S), .WALK_PERIOD(WP), .INIT_X(100), .INIT_Y(400)) dut (
        .pixel_clk_in   (clk),
        .rst_in         (rst_in),
        .hcount_in      (hcount_in),
        .vcount_in      (vcount_in),
        .frame_tick_in  (frame_tick_in),
        .mario_x_in     (mario_x_in),
        .mario_y_in     (mario_y_in),
        .moving_in      (moving_in),
        .facing_left_in (facing_left_in),
        .airborne_in    (airborne_in),
        .dead_in        (dead_in),
        .image_addr_out (image_addr_out),
        .in_sprite_out  (in_sprite_out),
        .frame_idx_out  (frame_idx_out)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: state 0 stand, 1 walk, 2 jump, 3 dead; walk_n counts ticks since entering walk.
    int  m_x, m_y, m_state, m_walk_n, m_frame;
    bit  m_face;

    function automatic int frame_of(input int st, input int n);
        case (st)
            1:       return 1 + (n / WP) % 3;
            2:       return 4;
            3:       return 5;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_x = 100; m_y = 400; m_face = 0;
        m_state = 0; m_walk_n = 0; m_frame = 0;
    endtask

    task automatic model_tick();
        int ns;
        if (m_state == 3 || dead_in) ns = 3;
        else if (airborne_in)        ns = 2;
        else if (moving_in)          ns = 1;
        else                         ns = 0;
        m_walk_n = (ns == 1 && m_state == 1) ? m_walk_n + 1 : 0;
        m_state  = ns;
        m_frame  = frame_of(m_state, m_walk_n);
        m_x = int'(mario_x_in);
        m_y = int'(mario_y_in);
        m_face = facing_left_in;
    endtask

    // One pixel clock: drive, predict from pre-edge model, advance, compare after edge.
    task automatic cyc(input int h, input int v, input bit tick);
        int dx, dy, col, exp_in, exp_addr;
        hcount_in     = 11'(h);
        vcount_in     = 10'(v);
        frame_tick_in = tick;
        dx = h - m_x;
        dy = v - m_y;
        exp_in = (dx >= 0 && dx < (16 << S) && dy >= 0 && dy < (32 << S)) ? 1 : 0;
        col = exp_in ? (dx >> S) : 0;
`ifdef MARIO_FLIP_EN
        if (m_face) col = 15 - col;
`endif
        exp_addr = exp_in ? m_frame * 512 + (dy >> S) * 16 + col : 0;
        if (tick) model_tick();
        @(posedge clk);
        #1;
        frame_tick_in = 1'b0;
        check("in_sprite", in_sprite_out, exp_in);
        check("image_addr", image_addr_out, exp_addr);
        check("frame_idx", frame_idx_out, m_frame);
    endtask

    task automatic do_reset(input int h, input int v);
        hcount_in = 11'(h);
        vcount_in = 10'(v);
        rst_in = 1'b1;
        @(posedge clk);
        #1;
        rst_in = 1'b0;
        model_reset();
        check("rst_in_sprite", in_sprite_out, 0);
        check("rst_addr", image_addr_out, 0);
        check("rst_frame", frame_idx_out, 0);
    endtask

    initial begin
        int h, v;
        model_reset();
        #1;
        do_reset(0, 0);

        // Box edges at reset position.
        cyc(100, 400, 0);  check("t1_left_in", in_sprite_out, 1); check("t1_left_addr", image_addr_out, 0);
        cyc(131, 400, 0);  check("t1_right_addr", image_addr_out, 15);
        cyc(132, 400, 0);  check("t1_past_right", in_sprite_out, 0);
        cyc(99, 400, 0);   check("t1_before_left", in_sprite_out, 0);
        cyc(100, 463, 0);  check("t1_bottom_in", in_sprite_out, 1);
        cyc(100, 464, 0);  check("t1_past_bottom", in_sprite_out, 0);

        // Walk cycle stepping.
        moving_in = 1'b1;
        for (int i = 1; i <= 19; i++) begin
            cyc(0, 0, 1);
            check("walk_frame", frame_idx_out, ((i - 1) / WP) % 3 + 1);
            cyc(100, 402, 0);
            check("walk_addr", image_addr_out, (((i - 1) / WP) % 3 + 1) * 512 + 16);
        end

        // Position change without a tick is held off until the tick.
        moving_in  = 1'b0;
        mario_x_in = 11'd300;
        cyc(100, 400, 0);  check("hold_old_x", in_sprite_out, 1);
        cyc(300, 400, 0);  check("hold_new_x", in_sprite_out, 0);
        cyc(0, 0, 1);
        cyc(300, 400, 0);  check("moved_new_x", in_sprite_out, 1);
        cyc(100, 400, 0);  check("moved_old_x", in_sprite_out, 0);

        // Death priority and stickiness.
        dead_in = 1'b1; airborne_in = 1'b1; moving_in = 1'b1;
        cyc(0, 0, 1);      check("dead_frame", frame_idx_out, 5);
        dead_in = 1'b0;
        repeat (10) cyc(0, 0, 1);
        check("dead_sticky", frame_idx_out, 5);
        airborne_in = 1'b0; moving_in = 1'b0;
        do_reset(0, 0);

        // Mirroring.
        facing_left_in = 1'b1;
        cyc(0, 0, 1);
        cyc(100, 400, 0);
`ifdef MARIO_FLIP_EN
        check("flip_addr", image_addr_out, 15);
`else
        check("flip_addr", image_addr_out, 0);
`endif
        facing_left_in = 1'b0;
        cyc(0, 0, 1);

        // Reset while walking and inside the box.
        moving_in  = 1'b1;
        mario_x_in = 11'd500;
        cyc(0, 0, 1);
        cyc(500, 400, 0);  check("pre_rst_in", in_sprite_out, 1);
        do_reset(500, 400);
        cyc(100, 400, 0);  check("post_rst_pos", in_sprite_out, 1);
        check("post_rst_addr", image_addr_out, 0);

        // Randomized traffic.
        for (int n = 0; n < 4000; n++) begin
            moving_in      = ($urandom % 8) != 0;
            airborne_in    = ($urandom % 6) == 0;
            dead_in        = ($urandom % 80) == 0;
            facing_left_in = $urandom % 2;
            mario_x_in     = 11'($urandom % 1280);
            mario_y_in     = 10'($urandom % 720);
            if ($urandom % 400 == 0) begin
                do_reset(int'($urandom % 2048), int'($urandom % 1024));
            end else begin
                if ($urandom % 4 == 0) begin
                    h = int'($urandom % 2048);
                    v = int'($urandom % 1024);
                end else begin
                    h = m_x + int'($urandom_range(0, 40)) - 4;
                    v = m_y + int'($urandom_range(0, 72)) - 4;
                    if (h < 0) h = 0;
                    if (h > 2047) h = 2047;
                    if (v < 0) v = 0;
                    if (v > 1023) v = 1023;
                end
                cyc(h, v, ($urandom % 8) == 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
